// File: rtl/ysyx_23060096_divider.sv
// ysyx_23060096_divider
//   Iterative restoring divider for RV32M DIV/DIVU/REM/REMU. One quotient
//   bit is produced per cycle, MSB first. Each trial subtraction goes
//   through the shared external 32-bit adder/subtractor over the add_*
//   ports.
//
//   Ports
//     clk, rst_n         clock, synchronous active-low reset
//     flush              abort any in-flight operation and drop its result
//     in_valid/in_ready  request handshake; carries in_dividend, in_divisor
//                        and in_signed (1 = DIV/REM, 0 = DIVU/REMU)
//     out_valid/out_ready
//                        response handshake; carries out_quotient,
//                        out_remainder and out_dbz (divide by zero)
//     add_a, add_b, add_op
//                        adder operands and op (1 = subtract); these are
//                        driven only in CALC and are zero elsewhere
//     add_result, add_carry
//                        adder result and carry-out (1 = no borrow)
//
//   Timing
//     A request accepted at edge T spends 32 cycles in CALC and 1 in FIX.
//     out_valid is high from the cycle after edge T+33. A zero divisor and
//     signed overflow both skip CALC, so out_valid is high right after edge T.
module ysyx_23060096_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_dividend,
  input  logic [XLEN-1:0] in_divisor,
  input  logic            in_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_quotient,
  output logic [XLEN-1:0] out_remainder,
  output logic            out_dbz,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  output logic            add_op,
  input  logic [XLEN-1:0] add_result,
  input  logic            add_carry
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic            dbz;
  } div_rsp_t;

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = '1;
  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(XLEN - 1);

  state_t          state;
  div_rsp_t        rsp;
  logic [XLEN-1:0] dq;      // dividend shifting out MSB-first, quotient shifting in
  logic [XLEN-1:0] dvs;     // divisor magnitude
  logic [XLEN-1:0] prem;    // partial remainder
  logic [CNT_W-1:0] cnt;
  logic            q_neg, r_neg;

  // Operand signs and magnitudes. Negation here is local, not the shared adder.
  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] abs_a, abs_b;
  assign sgn_a = in_signed & in_dividend[XLEN-1];
  assign sgn_b = in_signed & in_divisor[XLEN-1];
  assign abs_a = sgn_a ? (~in_dividend + 1'b1) : in_dividend;
  assign abs_b = sgn_b ? (~in_divisor  + 1'b1) : in_divisor;

  // The shifted-out remainder MSB acts as bit 32 of the trial value. When it
  // is set, the trial is already >= divisor, and the 32-bit difference is exact.
  logic [XLEN-1:0] trial;
  logic            hi, take;
  assign trial = {prem[XLEN-2:0], dq[XLEN-1]};
  assign hi    = prem[XLEN-1];
  assign take  = hi | add_carry;

  // The adder is driven combinationally so that its result can be consumed
  // in the same cycle.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_op = 1'b0;
    if (state == CALC) begin
      add_a  = trial;
      add_b  = dvs;
      add_op = 1'b1;
    end
  end

  assign out_quotient  = rsp.quo;
  assign out_remainder = rsp.rem;
  assign out_dbz       = rsp.dbz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rsp       <= '0;
      dq        <= '0;
      dvs       <= '0;
      prem      <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
    end else if (flush && state != IDLE) begin
      // flush wins over a pending out handshake
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            in_ready <= 1'b0;
            if (in_divisor == '0) begin
              rsp       <= '{quo: ALL_ONES, rem: in_dividend, dbz: 1'b1};
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (in_signed && in_dividend == INT_MIN && in_divisor == ALL_ONES) begin
              rsp       <= '{quo: INT_MIN, rem: '0, dbz: 1'b0};
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              dq    <= abs_a;
              dvs   <= abs_b;
              q_neg <= sgn_a ^ sgn_b;
              r_neg <= sgn_a;
              prem  <= '0;
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem <= take ? add_result : trial;
          dq   <= {dq[XLEN-2:0], take};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_IT) state <= FIX;
        end
        FIX: begin
          rsp.quo   <= q_neg ? -dq : dq;
          rsp.rem   <= r_neg ? -prem : prem;
          rsp.dbz   <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060096_divider.sv
// Scoreboard bench for ysyx_23060096_divider. Stimulus pushes the result
// expected from RV32M arithmetic. A negedge monitor pops that result on
// each output handshake and compares it with the DUT outputs. The bench
// also models the external adder/subtractor.
module tb_ysyx_23060096_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_dividend = '0;
  logic [31:0] in_divisor = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_quotient, out_remainder;
  logic        out_dbz;
  logic [31:0] add_a, add_b, add_result;
  logic        add_op, add_carry;

  ysyx_23060096_divider dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_dbz(out_dbz),
    .add_a(add_a), .add_b(add_b), .add_op(add_op),
    .add_result(add_result), .add_carry(add_carry)
  );

  always #5 clk = ~clk;

  // external adder/subtractor: op=1 -> a - b, carry=1 means no borrow
  logic [32:0] sum;
  assign sum = add_op ? ({1'b0, add_a} + {1'b0, ~add_b} + 33'd1)
                      : ({1'b0, add_a} + {1'b0, add_b});
  assign add_result = sum[31:0];
  assign add_carry  = sum[32];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;   // edges from accept to the first cycle out_valid is seen
    int          acc;
  } exp_t;

  exp_t sb[$];

  // RV32M reference model
  function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    int   sa, sb_;
    e.dbz = 1'b0;
    e.lat = 33;
    e.acc = 0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1; e.lat = 0;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.lat = 0;
    end else if (s) begin
      sa = a; sb_ = b;
      e.q = 32'(sa / sb_);
      e.r = 32'(sa % sb_);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // out_ready driver, applied 2 time units after each edge
  int bp_mode = 0;  // 0 always ready, 1 hold off, 2 random
  always @(posedge clk) begin
    #2;
    case (bp_mode)
      1:       out_ready = 1'b0;
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  // monitor
  logic        seen = 1'b0;
  logic        hs = 1'b0;
  int          first_cyc = 0;
  logic [31:0] snap_q = '0, snap_r = '0;
  logic        snap_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush) begin
      seen = 1'b0;
      hs = 1'b0;
    end else begin
      if (hs) begin
        chk("idle_after_hs_in_ready", {31'd0, in_ready}, 32'd1);
        hs = 1'b0;
      end
      if (out_valid) begin
        chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
        if (!seen) begin
          seen = 1'b1;
          first_cyc = cyc;
          snap_q = out_quotient; snap_r = out_remainder; snap_d = out_dbz;
        end else begin
          chk("hold_q", out_quotient, snap_q);
          chk("hold_r", out_remainder, snap_r);
          chk("hold_dbz", {31'd0, out_dbz}, {31'd0, snap_d});
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_out_valid: got q=%h r=%h with nothing outstanding", out_quotient, out_remainder);
          end else begin
            e = sb.pop_front();
            chk("quotient", out_quotient, e.q);
            chk("remainder", out_remainder, e.r);
            chk("dbz", {31'd0, out_dbz}, {31'd0, e.dbz});
            chk("latency", 32'(first_cyc - e.acc), 32'(e.lat));
          end
          seen = 1'b0;
          hs = 1'b1;
        end
      end
    end
  end

  // Issue one request. Call and return at #1 after a posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit push, input bit op_chk);
    int   n = 0;
    exp_t e;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 400 cycles");
    end
    in_valid = 1'b1; in_dividend = a; in_divisor = b; in_signed = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = ref_div(a, b, s);
    e.acc = cyc;
    if (push) sb.push_back(e);
    if (op_chk) begin
      for (int i = 0; i < 32; i++) begin
        chk("add_op_calc", {31'd0, add_op}, 32'd1);
        @(posedge clk); #1;
      end
      chk("add_op_fix", {31'd0, add_op}, 32'd0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_q"}, out_quotient, 32'd0);
    chk({tag, "_r"}, out_remainder, 32'd0);
    chk({tag, "_dbz"}, {31'd0, out_dbz}, 32'd0);
    chk({tag, "_add_a"}, add_a, 32'd0);
    chk({tag, "_add_b"}, add_b, 32'd0);
    chk({tag, "_add_op"}, {31'd0, add_op}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          n;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // main path, add_op must be high for all 32 CALC cycles
    issue(32'd100, 32'd7, 1'b0, 1'b1, 1'b1);
    drain();

    // directed corners
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b0);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
    issue(32'd5, 32'd0, 1'b0, 1'b1, 1'b0);
    issue(32'hFFFF_FFF0, 32'd0, 1'b1, 1'b1, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0);
    issue(32'h8000_0000, 32'd3, 1'b1, 1'b1, 1'b0);
    drain();

    // backpressure for 10 cycles, then a back-to-back request
    bp_mode = 1;
    issue(32'd123, 32'd10, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
    bp_mode = 0;
    issue(32'hDEAD_BEEF, 32'd17, 1'b1, 1'b1, 1'b0);
    drain();

    // flush in IDLE: a concurrent request is ignored
    in_valid = 1'b1; flush = 1'b1; in_dividend = 32'd9; in_divisor = 32'd3; in_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);

    // flush mid-CALC: the result never appears
    issue(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_calc_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_calc_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_no_late_valid", {31'd0, out_valid}, 32'd0);

    // randomized traffic with random backpressure
    bp_mode = 2;
    for (int k = 0; k < 300; k++) begin
      a = $urandom(); b = $urandom(); s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = b | 32'h8000_0000;
        4: a = $urandom_range(0, 100);
        default: ;
      endcase
      issue(a, b, s, 1'b1, 1'b0);
    end
    drain();
    bp_mode = 0;

    // reset mid-CALC after a nonzero result is held on the outputs
    issue(32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
    drain();
    issue(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("mid_reset");
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("reset_no_late_valid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
